// File: rtl/bp_update_sched.sv
// Retire-side scheduler feeding the branch predictor's single update port.
// Optional BP_SCHED_STATS_EN adds saturating update/mispredict counters.
`ifndef OBQ_SIZE
`define OBQ_SIZE 16
`endif

module bp_update_sched #(
    parameter int RT_WIDTH       = 2,
    parameter int QUEUE_DEPTH    = 8,
    parameter int IDX_W          = $clog2(`OBQ_SIZE) + 1,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [RT_WIDTH-1:0]                rt_valid,
    input  logic [RT_WIDTH-1:0]                rt_taken,
    input  logic [RT_WIDTH-1:0]                rt_correct,
    input  logic [RT_WIDTH-1:0][31:0]          rt_pc,
    input  logic [RT_WIDTH-1:0][31:0]          rt_target,
    input  logic [RT_WIDTH-1:0][IDX_W-1:0]     rt_obq_idx,
    output logic                               rt_ready,
    output logic                               bp_en_branch,
    output logic                               bp_branch_taken,
    output logic                               bp_prediction_correct,
    output logic [31:0]                        bp_pc,
    output logic [31:0]                        bp_calculated_pc,
    output logic [IDX_W-1:0]                   bp_branch_index,
    output logic                               fetch_bp_stall,
`ifdef BP_SCHED_STATS_EN
    output logic [31:0]                        stat_updates,
    output logic [31:0]                        stat_mispredicts,
`endif
    output logic [$clog2(QUEUE_DEPTH):0]       count_out
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LN_W  = $clog2(RT_WIDTH + 1);

    typedef struct packed {
        logic             taken;
        logic             correct;
        logic [31:0]      pc;
        logic [31:0]      target;
        logic [IDX_W-1:0] idx;
    } entry_t;

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    entry_t           mem [QUEUE_DEPTH];
    entry_t           lane_e [RT_WIDTH];
    entry_t           byp_e;
    entry_t           head_e;
    logic [PTR_W-1:0] wr_idx [RT_WIDTH];
    logic [RT_WIDTH-1:0] wr_en;
    logic [LN_W-1:0]  wr_cnt;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    state_t           state_q;
    state_t           state_d;
    logic [3:0]       rcnt_q;
    logic [3:0]       rcnt_d;
    logic             byp_hit;
    logic             avail;
    logic             pop;
    logic             stall_d;

    assign rt_ready  = (QUEUE_DEPTH - int'(count_q)) >= RT_WIDTH;
    assign count_out = count_q;

    always_comb begin
        for (int i = 0; i < RT_WIDTH; i++) begin
            lane_e[i].taken   = rt_taken[i];
            lane_e[i].correct = rt_correct[i];
            lane_e[i].pc      = rt_pc[i];
            lane_e[i].target  = rt_target[i];
            lane_e[i].idx     = rt_obq_idx[i];
        end
    end

    // Valid lanes pack into consecutive slots starting at the tail.
    always_comb begin
        wr_cnt = '0;
        wr_en  = '0;
        for (int i = 0; i < RT_WIDTH; i++) begin
            wr_idx[i] = tail_q + PTR_W'(wr_cnt);
            wr_en[i]  = rt_ready & rt_valid[i];
            if (wr_en[i]) wr_cnt = wr_cnt + LN_W'(1);
        end
    end

    // An empty queue forwards the oldest incoming lane straight to issue.
    always_comb begin
        byp_e   = lane_e[0];
        byp_hit = 1'b0;
        for (int i = 0; i < RT_WIDTH; i++) begin
            if (rt_valid[i] && !byp_hit) begin
                byp_e   = lane_e[i];
                byp_hit = 1'b1;
            end
        end
    end

    assign avail  = (count_q != '0) || (rt_ready && byp_hit);
    assign head_e = (count_q == '0) ? byp_e : mem[head_q];

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pop     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (avail) begin
                    pop = 1'b1;
                    if (!head_e.correct) begin
                        state_d = RECOVER;
                        rcnt_d  = 4'(RECOVER_CYCLES);
                    end
                end
            end
            RECOVER: begin
                rcnt_d = rcnt_q - 4'd1;
                if (rcnt_q == 4'd1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign stall_d = (state_q == RECOVER) || (pop && !head_e.correct);
    assign count_d = count_q + CNT_W'(wr_cnt) - CNT_W'(pop);

    always_ff @(posedge clock) begin
        for (int i = 0; i < RT_WIDTH; i++) begin
            if (wr_en[i]) mem[wr_idx[i]] <= lane_e[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q                <= '0;
            tail_q                <= '0;
            count_q               <= '0;
            state_q               <= RUN;
            rcnt_q                <= '0;
            bp_en_branch          <= 1'b0;
            bp_branch_taken       <= 1'b0;
            bp_prediction_correct <= 1'b0;
            bp_pc                 <= '0;
            bp_calculated_pc      <= '0;
            bp_branch_index       <= '0;
            fetch_bp_stall        <= 1'b0;
        end else begin
            head_q         <= head_q + PTR_W'(pop);
            tail_q         <= tail_q + PTR_W'(wr_cnt);
            count_q        <= count_d;
            state_q        <= state_d;
            rcnt_q         <= rcnt_d;
            bp_en_branch   <= pop;
            fetch_bp_stall <= stall_d;
            if (pop) begin
                bp_branch_taken       <= head_e.taken;
                bp_prediction_correct <= head_e.correct;
                bp_pc                 <= head_e.pc;
                bp_calculated_pc      <= head_e.target;
                bp_branch_index       <= head_e.idx;
            end
        end
    end

`ifdef BP_SCHED_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (bp_en_branch) begin
            if (stat_updates != '1)
                stat_updates <= stat_updates + 32'd1;
            if (!bp_prediction_correct && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
